// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with its own index register.
// The index comes either straight from A (direct mode) or from a small stepping
// sequencer (scan-up, scan-down, one-shot sweep). Y is always one-hot or zero.
module decoder_seq #(
  parameter int unsigned N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [N-1:0]      A,
  input  logic              LOAD,
  input  logic              STEP,
  output logic [(1<<N)-1:0] Y,
  output logic [N-1:0]      IDX,
  output logic              WRAP,
  output logic              DONE
);

  localparam int unsigned M = 1 << N;
  localparam logic [N-1:0] IdxMax = '1;
  localparam logic [N-1:0] IdxOne = N'(1);

  localparam logic [1:0] ModeDirect = 2'b00;
  localparam logic [1:0] ModeUp     = 2'b01;
  localparam logic [1:0] ModeDown   = 2'b10;
  localparam logic [1:0] ModeSweep  = 2'b11;

  logic [N-1:0] idx_q, idx_d;
  logic [M-1:0] y_q, y_d;
  logic         wrap_q, wrap_d;
  logic         done_q, done_d;

  // State register: index, decoded output, wrap pulse and sticky sweep flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  // Next index / flags; LOAD beats STEP, and disabled cycles freeze IDX and DONE.
  always_comb begin
    idx_d  = idx_q;
    done_d = done_q;
    wrap_d = 1'b0;
    if (EN) begin
      unique case (MODE)
        ModeDirect: begin
          idx_d  = A;
          done_d = 1'b0;
        end
        ModeUp: begin
          done_d = 1'b0;
          if (LOAD) begin
            idx_d = A;
          end else if (STEP) begin
            idx_d  = idx_q + IdxOne;
            wrap_d = (idx_q == IdxMax);
          end
        end
        ModeDown: begin
          done_d = 1'b0;
          if (LOAD) begin
            idx_d = A;
          end else if (STEP) begin
            idx_d  = idx_q - IdxOne;
            wrap_d = (idx_q == '0);
          end
        end
        ModeSweep: begin
          if (LOAD) begin
            idx_d  = A;
            done_d = (A == IdxMax);
          end else if (STEP) begin
            // Sweep stops at the top and never wraps.
            if (!done_q && (idx_q != IdxMax)) begin
              idx_d  = idx_q + IdxOne;
              done_d = ((idx_q + IdxOne) == IdxMax);
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          idx_d = idx_q;
        end
      endcase
    end
  end

  // Decode from the next index so Y lines up with IDX in the same cycle.
  always_comb begin
    y_d = '0;
    if (EN) begin
      y_d = M'(1) << idx_d;
    end
  end

  assign Y    = y_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: three instances (N=3, 1, 5) on shared controls.
// Stimulus pushes expected results into a queue; a monitor pops one entry per
// clock and compares it against the selected instance.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, en, load, step;
  logic [1:0] mode;
  logic [4:0] a;

  logic [7:0]  y0;  logic [2:0] idx0; logic wrap0, done0;
  logic [1:0]  y1;  logic [0:0] idx1; logic wrap1, done1;
  logic [31:0] y2;  logic [4:0] idx2; logic wrap2, done2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [31:0] y;
    logic [4:0]  idx;
    logic        wrap;
    logic        done;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_seq #(.N(3)) u_dut3 (
    .clk(clk), .rst(rst), .EN(en), .MODE(mode), .A(a[2:0]), .LOAD(load), .STEP(step),
    .Y(y0), .IDX(idx0), .WRAP(wrap0), .DONE(done0)
  );

  decoder_seq #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .EN(en), .MODE(mode), .A(a[0:0]), .LOAD(load), .STEP(step),
    .Y(y1), .IDX(idx1), .WRAP(wrap1), .DONE(done1)
  );

  decoder_seq #(.N(5)) u_dut5 (
    .clk(clk), .rst(rst), .EN(en), .MODE(mode), .A(a), .LOAD(load), .STEP(step),
    .Y(y2), .IDX(idx2), .WRAP(wrap2), .DONE(done2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: one expected entry per clock, sampled just after the edge.
  initial begin
    exp_t        e;
    logic [31:0] ay;
    logic [4:0]  ai;
    logic        aw, ad;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          1:       begin ay = {30'b0, y1}; ai = {4'b0, idx1}; aw = wrap1; ad = done1; end
          2:       begin ay = y2;          ai = idx2;         aw = wrap2; ad = done2; end
          default: begin ay = {24'b0, y0}; ai = {2'b0, idx0}; aw = wrap0; ad = done0; end
        endcase
        chk({e.name, " Y"},    ay, e.y);
        chk({e.name, " IDX"},  {27'b0, ai}, {27'b0, e.idx});
        chk({e.name, " WRAP"}, {31'b0, aw}, {31'b0, e.wrap});
        chk({e.name, " DONE"}, {31'b0, ad}, {31'b0, e.done});
        chk({e.name, " onehot"}, (ay & (ay - 32'd1)), 32'd0);
      end
    end
  end

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] m, input logic [4:0] av,
                     input logic ld, input logic st, input int d, input logic [31:0] ey,
                     input logic [4:0] ei, input logic ew, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; a = av; load = ld; step = st;
    x.dut = d; x.y = ey; x.idx = ei; x.wrap = ew; x.done = ed; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b01; a = '0; load = 1'b0; step = 1'b1;

    // Reset overrides EN/STEP in scan-up mode.
    cyc(1, 1, 2'b01, 0, 0, 1, 0, 32'h0, 0, 0, 0, "reset");
    cyc(1, 1, 2'b01, 0, 0, 1, 0, 32'h0, 0, 0, 0, "reset2");

    // Direct decode of every address.
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 2'b00, 5'(i), 0, 0, 0, 32'h1 << i, 5'(i), 0, 0, "direct");
    cyc(0, 0, 2'b00, 5, 0, 0, 0, 32'h0, 7, 0, 0, "direct_en0");

    // Scan-up across the wrap.
    cyc(0, 1, 2'b01, 6, 1, 0, 0, 32'h40, 6, 0, 0, "up_load");
    cyc(0, 1, 2'b01, 0, 0, 1, 0, 32'h80, 7, 0, 0, "up_step7");
    cyc(0, 1, 2'b01, 0, 0, 1, 0, 32'h01, 0, 1, 0, "up_wrap");
    cyc(0, 1, 2'b01, 0, 0, 1, 0, 32'h02, 1, 0, 0, "up_step1");
    cyc(0, 1, 2'b01, 0, 0, 0, 0, 32'h02, 1, 0, 0, "up_idle");

    // Scan-down across the wrap, then LOAD beats STEP.
    cyc(0, 1, 2'b10, 1, 1, 0, 0, 32'h02, 1, 0, 0, "dn_load");
    cyc(0, 1, 2'b10, 0, 0, 1, 0, 32'h01, 0, 0, 0, "dn_step0");
    cyc(0, 1, 2'b10, 0, 0, 1, 0, 32'h80, 7, 1, 0, "dn_wrap");
    cyc(0, 1, 2'b10, 4, 1, 1, 0, 32'h10, 4, 0, 0, "dn_ldstep");
    cyc(0, 0, 2'b10, 0, 0, 1, 0, 32'h00, 4, 0, 0, "dn_en0");
    cyc(0, 1, 2'b10, 0, 0, 0, 0, 32'h10, 4, 0, 0, "dn_en1");

    // Sweep saturates at 7 with sticky DONE and no WRAP.
    cyc(0, 1, 2'b11, 5, 1, 0, 0, 32'h20, 5, 0, 0, "sw_load5");
    cyc(0, 1, 2'b11, 0, 0, 1, 0, 32'h40, 6, 0, 0, "sw_step6");
    cyc(0, 1, 2'b11, 0, 0, 1, 0, 32'h80, 7, 0, 1, "sw_step7");
    cyc(0, 1, 2'b11, 0, 0, 1, 0, 32'h80, 7, 0, 1, "sw_hold");
    cyc(0, 1, 2'b11, 0, 0, 1, 0, 32'h80, 7, 0, 1, "sw_hold2");
    cyc(0, 1, 2'b11, 2, 1, 0, 0, 32'h04, 2, 0, 0, "sw_load2");
    cyc(0, 1, 2'b11, 7, 1, 0, 0, 32'h80, 7, 0, 1, "sw_load7");
    cyc(0, 0, 2'b01, 0, 0, 0, 0, 32'h00, 7, 0, 1, "sw_en0");
    cyc(0, 1, 2'b01, 0, 0, 0, 0, 32'h80, 7, 0, 0, "sw_leave");
    cyc(0, 1, 2'b11, 3, 1, 0, 0, 32'h08, 3, 0, 0, "sw_load3");
    cyc(1, 1, 2'b11, 0, 0, 1, 0, 32'h00, 0, 0, 0, "sw_reset");

    // N=1 wraps at 1.
    cyc(1, 1, 2'b01, 0, 0, 0, 1, 32'h0, 0, 0, 0, "n1_reset");
    cyc(0, 1, 2'b01, 0, 1, 0, 1, 32'h1, 0, 0, 0, "n1_load");
    cyc(0, 1, 2'b01, 0, 0, 1, 1, 32'h2, 1, 0, 0, "n1_step");
    cyc(0, 1, 2'b01, 0, 0, 1, 1, 32'h1, 0, 1, 0, "n1_wrap");

    // N=5 wraps at 31.
    cyc(1, 1, 2'b01, 0, 0, 0, 2, 32'h0, 0, 0, 0, "n5_reset");
    cyc(0, 1, 2'b01, 30, 1, 0, 2, 32'h4000_0000, 30, 0, 0, "n5_load");
    cyc(0, 1, 2'b01, 0, 0, 1, 2, 32'h8000_0000, 31, 0, 0, "n5_step");
    cyc(0, 1, 2'b01, 0, 0, 1, 2, 32'h0000_0001, 0, 1, 0, "n5_wrap");
    cyc(0, 1, 2'b01, 0, 0, 0, 2, 32'h0000_0001, 0, 0, 0, "n5_idle");

    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered N-to-2^N one-hot decoder with an internal index register and four modes: direct decode, count-up scan, count-down scan and one-shot sweep. Generalises the combinational 3-to-8 decoder with enable into a clocked block that can drive chip-select, demux-select or row-strobe lines either from an external address or from its own stepping sequencer. Sits between a controller (address/step source) and 2^N one-hot consumers.

## Interface
- N, default 3: select width; number of outputs M = 2^N (N in 1..6).
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- EN  input  1  global enable; 0 forces Y to zero and freezes IDX.
- MODE  input  2  00 direct, 01 scan-up, 10 scan-down, 11 sweep.
- A  input  N  external select (direct mode) / load value (scan modes).
- LOAD  input  1  scan modes: IDX <= A, clears DONE.
- STEP  input  1  scan modes: advance IDX by one position.
- Y  output  M  registered one-hot output, Y[i]=1 iff IDX==i and enabled.
- IDX  output  N  current index register.
- WRAP  output  1  one-cycle pulse when a scan step wraps.
- DONE  output  1  sweep mode: high when sweep reached M-1; sticky.

## Operation
- Reset (rst=1 at edge, overrides everything): IDX=0, Y=0, WRAP=0, DONE=0.
- EN=0: IDX, DONE hold; Y<=0; WRAP<=0; LOAD/STEP ignored.
- EN=1, priority per cycle: LOAD > STEP; applies in modes 01/10/11 only.
- Mode 00 (direct): IDX<=A every cycle; LOAD/STEP ignored; WRAP=0.
- Mode 01 (scan-up): STEP: IDX<=IDX+1 mod M; if IDX was M-1, WRAP pulses.
- Mode 10 (scan-down): STEP: IDX<=IDX-1 mod M; if IDX was 0, WRAP pulses.
- Mode 11 (sweep): STEP with IDX<M-1: IDX<=IDX+1; when the new IDX equals M-1, DONE<=1. STEP with DONE=1 or IDX=M-1: IDX holds, DONE<=1, no WRAP. LOAD clears DONE (DONE<=1 if A==M-1).
- Y is computed from the next value of IDX: Y<=EN ? (1<<IDX_next) : 0. Y is always one-hot or all-zero, never multi-hot.
- Mode change takes effect at the next edge; IDX is not cleared by a mode change; DONE is cleared when leaving mode 11.
- Index arithmetic is N-bit unsigned, wrap by natural modulo 2^N.

## Timing
- Latency: A/LOAD/STEP sampled at edge k -> IDX and Y updated at edge k (visible cycle k+1); one cycle input-to-Y.
- EN falling: Y=0 from the next edge; EN rising: Y = one-hot(IDX, or A in direct mode) from the next edge.
- WRAP high exactly one cycle per wrapping STEP; consecutive STEPs across wrap give one WRAP per wrap.
- rst asserted mid-scan/sweep: all outputs at reset value after that edge regardless of LOAD/STEP/EN.
- LOAD and STEP together: LOAD wins, no step, no WRAP.

## Test plan
- Reset: N=3, drive rst=1 with EN=1, STEP=1, MODE=01 -> next cycle Y=0, IDX=0, WRAP=0, DONE=0.
- Direct: MODE=00, EN=1, A=0..7 one per cycle -> Y = 8'h01,02,04..80 each one cycle later; EN=0 with A=5 -> Y=0, IDX holds previous.
- Scan-up wrap: LOAD A=6, then 3 STEPs -> IDX 7,0,1; Y 8'h80,01,02; WRAP high only on the 7->0 cycle.
- Scan-down wrap + priority: LOAD A=1, STEP, STEP -> IDX 0,7, WRAP on 0->7; LOAD=1,STEP=1,A=4 same cycle -> IDX=4, WRAP=0.
- Sweep: MODE=11, LOAD A=5, 4 STEPs -> IDX 6,7,7,7; DONE rises with IDX=7 and stays; WRAP never; LOAD A=2 -> DONE=0, IDX=2.
- Parameter: N=1 and N=5 -> scan-up wraps at 1 and 31 respectively, Y width 2 and 32, exactly one bit set.
